// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h1000_0000;
    localparam int          FIFO_DEPTH_DEFAULT = 2;
    localparam logic [31:0] INSTR_BYTES        = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; the head is held in its own register so
// decode sees a flop output rather than a storage-array read.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  fetch_entry_t                 data_i,
    output fetch_entry_t                 head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   head_q, head_d;
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d, rd_nxt;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push, do_pop;

    always_comb begin
        do_push = push_i & !flush_i;
        do_pop  = pop_i & !flush_i & (cnt_q != '0);
        rd_nxt  = rd_q + AW'(1);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_nxt : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        head_d  = head_q;
        // The next-oldest entry moves up on a pop; a push into an empty queue goes straight to the head.
        if (do_pop) begin
            if (cnt_q > CW'(1)) begin
                head_d = mem_q[rd_nxt];
            end else if (do_push) begin
                head_d = data_i;
            end
        end else if (cnt_q == '0 && do_push) begin
            head_d = data_i;
        end
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    assign head_o  = head_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Pipelined instruction fetch with credit-limited requests, prefetch FIFO and redirect flush.
// Define IFETCH_MISALIGN_CHK_EN to report misaligned redirect targets through instr_err_o.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
`ifdef IFETCH_MISALIGN_CHK_EN
    output logic        instr_err_o,
`endif
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int              CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]     DEPTH_L = (CW+1)'(FIFO_DEPTH);

    fetch_state_e   state_q, state_d;
    logic [31:0]    fpc_q, fpc_d, rpc_q, rpc_d, redir_pc;
    logic [CW-1:0]  out_q, out_d, disc_q, disc_d, fifo_cnt;
    logic [CW:0]    inflight;
    logic           fifo_full, fifo_empty, fifo_pop, credit, fetch_ok;
    logic           grant, rv_ok, push;
    fetch_entry_t   head, push_entry;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic           err_pend_q, err_pend_d, stall_q, stall_d, err_show;
    logic [31:0]    err_pc_q, err_pc_d;
`endif

    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .data_i  (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
`ifdef IFETCH_MISALIGN_CHK_EN
        err_show      = err_pend_q & (state_q == FETCH) & !redirect_i;
        instr_err_o   = err_show;
        instr_valid_o = (!fifo_empty | err_show) & !redirect_i;
        instr_o       = err_show ? '0 : head.instr;
        instr_pc_o    = err_show ? err_pc_q : head.pc;
`else
        instr_valid_o = !fifo_empty & !redirect_i;
        instr_o       = head.instr;
        instr_pc_o    = head.pc;
`endif
    end

    // Credit counts both queued and in-flight words, so a granted request always has a FIFO slot.
    always_comb begin
        fifo_pop = instr_valid_o & instr_ready_i & !fifo_empty;
        inflight = {1'b0, out_q} + {1'b0, fifo_cnt} - (CW+1)'(fifo_pop);
        credit   = (inflight < DEPTH_L);
`ifdef IFETCH_MISALIGN_CHK_EN
        fetch_ok = !stall_q;
        redir_pc = redirect_pc_i;
`else
        fetch_ok = 1'b1;
        redir_pc = {redirect_pc_i[31:2], 2'b00};
`endif
    end

    always_comb begin
        mem_req_o  = (state_q == FETCH) & fetch_ok & credit;
        mem_addr_o = mem_req_o ? fpc_q : '0;
    end

    always_comb begin
        grant      = mem_req_o & mem_gnt_i;
        rv_ok      = mem_rvalid_i & (out_q != '0);
        push       = rv_ok & (state_q == FETCH) & !redirect_i;
        push_entry = '{pc: rpc_q, instr: mem_rdata_i};
        out_d      = out_q + CW'(grant) - CW'(rv_ok);
        disc_d     = disc_q;
        if (redirect_i) begin
            disc_d = out_d;
        end else if (state_q == DRAIN) begin
            disc_d = disc_q - CW'(rv_ok);
        end
        fpc_d = fpc_q;
        rpc_d = rpc_q;
        if (redirect_i) begin
            fpc_d = redir_pc;
            rpc_d = redir_pc;
        end else begin
            if (grant) fpc_d = fpc_q + INSTR_BYTES;
            if (push)  rpc_d = rpc_q + INSTR_BYTES;
        end
`ifdef IFETCH_MISALIGN_CHK_EN
        err_pend_d = err_pend_q;
        stall_d    = stall_q;
        err_pc_d   = err_pc_q;
        if (redirect_i) begin
            err_pend_d = (redirect_pc_i[1:0] != 2'b00);
            stall_d    = (redirect_pc_i[1:0] != 2'b00);
            err_pc_d   = redirect_pc_i;
        end else if (err_show && instr_ready_i) begin
            err_pend_d = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   if (disc_d == '0) state_d = FETCH;
            default: state_d = RESET;
        endcase
        if (redirect_i) begin
            state_d = (disc_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q  <= RESET_PC;
            rpc_q  <= RESET_PC;
            out_q  <= '0;
            disc_q <= '0;
        end else begin
            fpc_q  <= fpc_d;
            rpc_q  <= rpc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pend_q <= 1'b0;
            stall_q    <= 1'b0;
            err_pc_q   <= '0;
        end else begin
            err_pend_q <= err_pend_d;
            stall_q    <= stall_d;
            err_pc_q   <= err_pc_d;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst) !(mem_rvalid_i && out_q == '0));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit against a small in-order memory responder.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        instr_err_o;
`endif
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        rsp_en;
    logic [31:0] addr_fifo [$];
    int          n_gnt = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          g0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
`ifdef IFETCH_MISALIGN_CHK_EN
        .instr_err_o   (instr_err_o),
`endif
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    // Memory: the word at address A reads back as ~A, one cycle after its grant when rsp_en is set.
    always @(posedge clk) begin
        if (rst) begin
            addr_fifo.delete();
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
        end else begin
            if (mem_req_o && mem_gnt_i) begin
                addr_fifo.push_back(mem_addr_o);
                n_gnt++;
            end
            if (rsp_en && addr_fifo.size() > 0) begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= ~addr_fifo.pop_front();
            end else begin
                mem_rvalid_i <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the caller at the falling edge of the first FETCH cycle.
    task automatic do_reset();
        rst        = 1'b1;
        redirect_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("req_low_in_RESET_state", {31'd0, mem_req_o}, 32'd0);
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        mem_gnt_i     = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        rsp_en        = 1'b1;
        repeat (3) tick();

        chk("rst_mem_req",     {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_addr",    mem_addr_o, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr",       instr_o, 32'd0);
        chk("rst_instr_pc",    instr_pc_o, 32'd0);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("rst_instr_err",   {31'd0, instr_err_o}, 32'd0);
`endif
        rst = 1'b0;
        chk("req_low_in_RESET_state", {31'd0, mem_req_o}, 32'd0);
        tick();
        chk("first_req",  {31'd0, mem_req_o}, 32'd1);
        chk("first_addr", mem_addr_o, 32'h1000_0000);

        // Streaming at one instruction per cycle.
        mem_gnt_i     = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stream_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("stream_pc",    instr_pc_o, 32'h1000_0000 + 32'(4 * i));
            chk("stream_instr", instr_o, ~(32'h1000_0000 + 32'(4 * i)));
            tick();
        end

        // Backpressure from the first fetch: credit stops issue after two grants.
        mem_gnt_i     = 1'b1;
        instr_ready_i = 1'b0;
        rsp_en        = 1'b1;
        do_reset();
        g0 = n_gnt;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_head_pc_stable", instr_pc_o, 32'h1000_0000);
            chk("bp_head_valid",     {31'd0, instr_valid_o}, 32'd1);
            if (i < 3) tick();
        end
        chk("bp_grant_count", 32'(n_gnt - g0), 32'd2);
        chk("bp_req_stopped", {31'd0, mem_req_o}, 32'd0);
        chk("bp_head_instr",  instr_o, ~32'h1000_0000);
        instr_ready_i = 1'b1;
        #1;
        chk("bp_resume_req",  {31'd0, mem_req_o}, 32'd1);
        chk("bp_resume_addr", mem_addr_o, 32'h1000_0008);
        tick();
        for (int i = 1; i < 4; i++) begin
            chk("bp_resume_pc",    instr_pc_o, 32'h1000_0000 + 32'(4 * i));
            chk("bp_resume_instr", instr_o, ~(32'h1000_0000 + 32'(4 * i)));
            tick();
        end

        // Grant stall holds the request.
        mem_gnt_i     = 1'b1;
        instr_ready_i = 1'b1;
        do_reset();
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req",  {31'd0, mem_req_o}, 32'd1);
            chk("stall_addr", mem_addr_o, 32'h1000_0004);
            if (i == 1) chk("stall_head_pc", instr_pc_o, 32'h1000_0000);
            if (i < 2) tick();
        end
        mem_gnt_i = 1'b1;
        tick();
        tick();
        chk("stall_after_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("stall_after_pc",    instr_pc_o, 32'h1000_0004);

        // Redirect with two requests outstanding.
        mem_gnt_i     = 1'b1;
        instr_ready_i = 1'b1;
        rsp_en        = 1'b0;
        do_reset();
        tick();
        tick();
        chk("redir_credit_full", {31'd0, mem_req_o}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h1000_0100;
        rsp_en        = 1'b1;
        #1;
        chk("redir_valid_low", {31'd0, instr_valid_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_no_req",   {31'd0, mem_req_o}, 32'd0);
            chk("drain_no_valid", {31'd0, instr_valid_o}, 32'd0);
            tick();
        end
        chk("post_drain_req",   {31'd0, mem_req_o}, 32'd1);
        chk("post_drain_addr",  mem_addr_o, 32'h1000_0100);
        chk("post_drain_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("post_drain_valid2", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("redir_target_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("redir_target_pc",    instr_pc_o, 32'h1000_0100);
        chk("redir_target_instr", instr_o, ~32'h1000_0100);

        // Redirect coinciding with rvalid and a queued head; target is misaligned.
        mem_gnt_i     = 1'b1;
        instr_ready_i = 1'b0;
        rsp_en        = 1'b1;
        do_reset();
        tick();
        tick();
        chk("t6_head_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("t6_rvalid_now", {31'd0, mem_rvalid_i}, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h1000_0102;
        instr_ready_i = 1'b1;
        #1;
        chk("t6_valid_masked", {31'd0, instr_valid_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        #1;
        chk("mis_no_req",   {31'd0, mem_req_o}, 32'd0);
        chk("mis_valid",    {31'd0, instr_valid_o}, 32'd1);
        chk("mis_err",      {31'd0, instr_err_o}, 32'd1);
        chk("mis_pc",       instr_pc_o, 32'h1000_0102);
        chk("mis_instr",    instr_o, 32'd0);
        tick();
        chk("mis_after_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("mis_after_err",   {31'd0, instr_err_o}, 32'd0);
        chk("mis_after_req",   {31'd0, mem_req_o}, 32'd0);
        tick();
        chk("mis_still_stalled", {31'd0, mem_req_o}, 32'd0);
`else
        #1;
        chk("t6_req",   {31'd0, mem_req_o}, 32'd1);
        chk("t6_addr",  mem_addr_o, 32'h1000_0100);
        chk("t6_no_stale_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("t6_no_stale_valid2", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("t6_target_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("t6_target_pc",    instr_pc_o, 32'h1000_0100);
        chk("t6_target_instr", instr_o, ~32'h1000_0100);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle RISC-V datapath.
- Replaces the bare PC register and combinational ROM lookup with a pipelined request/grant/response memory port and a small prefetch FIFO.
- Presents {pc, instr} to decode through a valid/ready handshake.
- Handles control-flow redirects by flushing queued instructions and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h1000_0000, PC fetched first after reset (start of text segment).
- FIFO_DEPTH, 2, prefetch entries and maximum outstanding requests; power of 2, range 2..8.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- mem_req_o  output  1  fetch request valid
- mem_addr_o  output  32  fetch byte address, word aligned
- mem_gnt_i  input  1  request accepted this cycle
- mem_rvalid_i  input  1  response data valid; responses return in order
- mem_rdata_i  input  32  instruction word
- instr_valid_o  output  1  instruction available to decode
- instr_o  output  32  instruction word
- instr_pc_o  output  32  PC of instr_o
- instr_ready_i  input  1  decode accepts instruction
- redirect_i  input  1  branch/jump taken; flush
- redirect_pc_i  input  32  new fetch PC

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk.
  - All outputs reset to 0; FIFO empty; counters zero; state RESET.
  - Fetch PC (fpc) resets to RESET_PC.
- FSM states:
  - RESET: one cycle after rst deasserts, go to FETCH.
  - FETCH: issue requests while credit is available.
  - DRAIN: no requests issued; go to FETCH when discard_cnt reaches 0.
- Credit rule:
  - mem_req_o=1 in FETCH when (outstanding + fifo_count - pop) < FIFO_DEPTH, where pop = instr_valid_o & instr_ready_i.
  - This gives one instruction per cycle with 1-cycle memory at FIFO_DEPTH=2.
- Request rules:
  - mem_addr_o = fpc.
  - Once mem_req_o is asserted, it and mem_addr_o stay stable until mem_gnt_i; only redirect_i may withdraw or change them.
- On grant: fpc += 4 (wraps mod 2^32); outstanding++.
- Response timing: mem_rvalid_i arrives no earlier than the cycle after its grant.
- On response (not discarded):
  - push {resp_pc, mem_rdata_i} into the FIFO; resp_pc += 4; outstanding--.
  - instr_valid_o rises the cycle after mem_rvalid_i, so minimum req-to-valid latency is 2 cycles.
- Decode handshake:
  - instr_valid_o = !fifo_empty & !redirect_i.
  - instr_o and instr_pc_o are the FIFO head and are held stable while valid & !ready.
  - Pop occurs on valid & ready.
- Redirect (highest priority):
  - Flush FIFO; fpc <= redirect_pc_i; resp_pc <= redirect_pc_i.
  - discard_cnt <= outstanding + grant_this_cycle - rvalid_this_cycle.
  - Any rvalid in the redirect cycle is dropped.
  - Next state is DRAIN if discard_cnt != 0, else FETCH.
  - The handshake in the redirect cycle does not count as a pop.
- In DRAIN, each mem_rvalid_i decrements discard_cnt and outstanding; data is dropped.
- A redirect during DRAIN updates fpc/resp_pc and keeps the remaining discard count; grants cannot occur in DRAIN.
- The FIFO never overflows by construction.
  - Push while full is an assertion failure.
  - Pop while empty cannot occur, since valid is low.
- An rvalid with outstanding==0 is an assertion failure and is ignored.
- Simultaneous push and pop are allowed at any occupancy.
- rst asserted mid-operation returns to the reset state immediately; in-flight responses after reset are ignored while outstanding==0.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHK_EN
- Defined:
  - Adds output instr_err_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 issues no memory request.
  - After any drain completes, present one entry with instr_valid_o=1, instr_err_o=1, instr_pc_o=redirect_pc_i, instr_o=0.
  - Then stall in FETCH with no requests until the next redirect.
- Undefined: redirect_pc_i[1:0] is forced to 2'b00; no error port.

Decomposition:
- ifetch_pkg:
  - fetch_state_e {RESET, FETCH, DRAIN}
  - fetch_entry_t {pc[31:0], instr[31:0]}
  - localparams RESET_PC_DEFAULT, FIFO_DEPTH_DEFAULT, INSTR_BYTES=4
- Sub-module ifetch_fifo:
  - Synchronous FIFO of fetch_entry_t with parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Head is registered-read.

Test Plan:
1. Reset: rst=1 -> mem_req_o=0, instr_valid_o=0; release -> first mem_addr_o=0x10000000 one cycle later.
2. Streaming, 1-cycle grant/response, instr_ready_i=1 -> instr_pc_o 0x10000000, 0x10000004, 0x10000008 on consecutive cycles, instr_o matches memory.
3. Backpressure: ready=0 for 6 cycles -> exactly 2 grants, then mem_req_o=0, head instr_pc_o=0x10000000 stable; ready=1 resumes in order.
4. Grant stall: mem_gnt_i=0 for 3 cycles -> mem_req_o=1, mem_addr_o=0x10000004 held stable throughout.
5. Redirect with 2 outstanding to 0x10000100 -> both responses dropped, state DRAIN for 2 responses, next valid instr_pc_o=0x10000100.
6. Redirect and rvalid in the same cycle, plus pop blocked -> no stale instruction is delivered.
   - Option: redirect to 0x10000102 with macro defined -> instr_err_o=1, instr_pc_o=0x10000102, no request.
   - Without macro -> fetch from 0x10000100.
